// File: rtl/data_memory_unit.sv
// ==== data_memory_unit: big-endian byte memory with a byte-serial load/store engine | rev 1.0 ====
`default_nettype none

module data_memory_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Clr_n,
    input  logic              E,
    input  logic              RW,
    input  logic              size,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       DI,
    output logic [31:0]       DO,
    output logic              busy,
    output logic              done
);

    localparam int c_DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t            r_state;
    logic [1:0]        r_beat;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_di;
    logic              r_rw;
    logic              r_size;
    logic [23:0]       r_asm;
    logic [7:0]        r_mem [c_DEPTH];

    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_rbyte;
    logic [7:0]        w_wbyte;
    logic              w_last;
    logic              w_beat;

    // Beat address wraps naturally at the top of the address space.
    assign w_addr  = r_addr + ADDR_W'(r_beat);
    assign w_rbyte = r_mem[w_addr];
    assign w_last  = r_size || (r_beat == 2'd3);
    assign w_beat  = (r_state == S_XFER);

    always_comb begin
        w_wbyte = r_di[7:0];
        if (!r_size) begin
            case (r_beat)
                2'd0:    w_wbyte = r_di[31:24];
                2'd1:    w_wbyte = r_di[23:16];
                2'd2:    w_wbyte = r_di[15:8];
                default: w_wbyte = r_di[7:0];
            endcase
        end
    end

    // Storage has no reset: an aborted store keeps the bytes it already wrote.
    always_ff @(posedge Clk) begin
        if (w_beat && r_rw) begin
            r_mem[w_addr] <= w_wbyte;
        end
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            r_state <= S_IDLE;
            r_beat  <= 2'd0;
            r_addr  <= '0;
            r_di    <= 32'd0;
            r_rw    <= 1'b0;
            r_size  <= 1'b0;
            r_asm   <= 24'd0;
            DO      <= 32'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (E) begin
                        r_addr  <= A;
                        r_di    <= DI;
                        r_rw    <= RW;
                        r_size  <= size;
                        r_beat  <= 2'd0;
                        busy    <= 1'b1;
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (!r_rw) begin
                        r_asm <= {r_asm[15:0], w_rbyte};
                    end
                    if (w_last) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        if (!r_rw) begin
                            DO <= r_size ? {24'd0, w_rbyte} : {r_asm, w_rbyte};
                        end
                    end else begin
                        r_beat <= r_beat + 2'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
